// File: rtl/univ_shift_reg_n_if.sv
// rtl/univ_shift_reg_n_if.sv - control/data bundle for the universal shift register
// Control, data and status signals grouped; clk and CR stay outside as plain ports.
interface univ_shift_reg_n_if #(parameter int WIDTH = 8);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             SR;
  logic             SL;
  logic             burst_start;
  logic [CW-1:0]    burst_cnt;
  logic             burst_dir;
  logic             rot;
  logic [WIDTH-1:0] Q;
  logic             ser_out_r;
  logic             ser_out_l;
  logic             busy;
  logic             done;

  modport master (
    output mode, par_in, SR, SL, burst_start, burst_cnt, burst_dir, rot,
    input  Q, ser_out_r, ser_out_l, busy, done
  );

  modport slave (
    input  mode, par_in, SR, SL, burst_start, burst_cnt, burst_dir, rot,
    output Q, ser_out_r, ser_out_l, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_n.sv
// rtl/univ_shift_reg_n.sv - N-bit universal shift register with burst shift engine
// Optional ROTATE_EN: rot=1 replaces the serial fill with the wrap-around bit.
module univ_shift_reg_n #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                CR,
  univ_shift_reg_n_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_done, w_done_nxt;
  logic [CW-1:0]    w_cnt_clamp;
  logic             w_fill_r_mode, w_fill_l_mode;
  logic             w_fill_r_burst, w_fill_l_burst;

  assign w_cnt_clamp = (bus.burst_cnt > CW'(WIDTH)) ? CW'(WIDTH) : bus.burst_cnt;

`ifdef ROTATE_EN
  logic r_rot, w_rot_nxt;
  assign w_fill_r_mode  = bus.rot ? r_q[WIDTH-1] : bus.SR;
  assign w_fill_l_mode  = bus.rot ? r_q[0]       : bus.SL;
  // Burst uses the rot value captured at start; SR/SL remain live per edge.
  assign w_fill_r_burst = r_rot ? r_q[WIDTH-1] : bus.SR;
  assign w_fill_l_burst = r_rot ? r_q[0]       : bus.SL;
`else
  assign w_fill_r_mode  = bus.SR;
  assign w_fill_l_mode  = bus.SL;
  assign w_fill_r_burst = bus.SR;
  assign w_fill_l_burst = bus.SL;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
`ifdef ROTATE_EN
    w_rot_nxt   = r_rot;
`endif
    case (r_state)
      IDLE: begin
        if (bus.burst_start) begin
          w_cnt_nxt = w_cnt_clamp;
          w_dir_nxt = bus.burst_dir;
`ifdef ROTATE_EN
          w_rot_nxt = bus.rot;
`endif
          if (w_cnt_clamp == '0) w_done_nxt  = 1'b1;
          else                   w_state_nxt = SHIFT;
        end else begin
          case (bus.mode)
            2'b01:   w_q_nxt = {r_q[WIDTH-2:0], w_fill_r_mode};
            2'b10:   w_q_nxt = {w_fill_l_mode, r_q[WIDTH-1:1]};
            2'b11:   w_q_nxt = bus.par_in;
            default: w_q_nxt = r_q;
          endcase
        end
      end
      SHIFT: begin
        w_q_nxt   = r_dir ? {w_fill_l_burst, r_q[WIDTH-1:1]}
                          : {r_q[WIDTH-2:0], w_fill_r_burst};
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CR) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
`ifdef ROTATE_EN
      r_rot   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
`ifdef ROTATE_EN
      r_rot   <= w_rot_nxt;
`endif
    end
  end

  assign bus.Q         = r_q;
  assign bus.ser_out_r = r_q[WIDTH-1];
  assign bus.ser_out_l = r_q[0];
  assign bus.busy      = (r_state == SHIFT);
  assign bus.done      = r_done;
endmodule

// File: tb/tb_univ_shift_reg_n.sv
// tb/tb_univ_shift_reg_n.sv - scoreboard testbench for univ_shift_reg_n (ROTATE_EN aware)
module tb_univ_shift_reg_n;
  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic cr;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e;

  univ_shift_reg_n_if #(.WIDTH(8)) bus ();

  univ_shift_reg_n #(.WIDTH(8)) dut (
    .clk (clk),
    .CR  (cr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] q, input logic busy, input logic done);
    exp_t x;
    x.q = q; x.busy = busy; x.done = done;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    bus.mode = 2'b11; bus.par_in = 8'hFF;
    push(8'hFF, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL reset_preload: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    cr = 1'b1;
    push(8'h00, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL reset_clear: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    cr = 1'b0; bus.par_in = 8'hA5;
    push(8'hA5, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL load_a5: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    checks++;
    if ({bus.ser_out_r, bus.ser_out_l} !== 2'b11) begin
      errors++;
      $display("FAIL ser_out_a5: got %b, expected 11", {bus.ser_out_r, bus.ser_out_l});
    end
  endtask

  task automatic test_modes();
    bus.mode = 2'b01; bus.SR = 1'b1;
    push(8'h4B, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL shift_right: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.mode = 2'b10; bus.SL = 1'b0;
    push(8'h25, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL shift_left: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.mode = 2'b00; bus.par_in = 8'hFF; bus.SR = 1'b1; bus.SL = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h25, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL hold: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    checks++;
    if ({bus.ser_out_r, bus.ser_out_l} !== 2'b01) begin
      errors++;
      $display("FAIL ser_out_25: got %b, expected 01", {bus.ser_out_r, bus.ser_out_l});
    end
  endtask

  task automatic test_burst();
    bus.mode = 2'b11; bus.par_in = 8'h81;
    push(8'h81, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL burst_load: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    // mode=11 with par_in=FF stays asserted throughout and must never land
    bus.burst_start = 1'b1; bus.burst_cnt = 4'd3; bus.burst_dir = 1'b0;
    bus.SR = 1'b0; bus.par_in = 8'hFF;
    push(8'h81, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL burst_start: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b0;
    push(8'h02, 1'b1, 1'b0);
    push(8'h04, 1'b1, 1'b0);
    push(8'h08, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL burst_shift: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.mode = 2'b00;
    push(8'h08, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL burst_after: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_zero_and_clamp();
    logic [7:0] m;
    bus.burst_start = 1'b1; bus.burst_cnt = 4'd0; bus.mode = 2'b11; bus.par_in = 8'hFF;
    push(8'h08, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL burst_zero: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b0; bus.mode = 2'b00;
    push(8'h08, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL burst_zero_after: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b1; bus.burst_cnt = 4'd15; bus.burst_dir = 1'b0; bus.SR = 1'b1;
    push(8'h08, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL clamp_start: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b0;
    m = 8'h08;
    for (int i = 0; i < 8; i++) begin
      m = {m[6:0], 1'b1};
      push(m, (i < 7), (i == 7));
    end
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL clamp_shift: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    // issued while done is still high from the clamped burst
    bus.burst_start = 1'b1; bus.burst_cnt = 4'd1; bus.burst_dir = 1'b1; bus.SL = 1'b0;
    push(8'hFF, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL b2b_start: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b0;
    push(8'h7F, 1'b0, 1'b1);
    push(8'h7F, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL b2b_shift: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bus.mode = 2'b11; bus.par_in = 8'h81;
    push(8'h81, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL abort_load: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.mode = 2'b00; bus.burst_start = 1'b1; bus.burst_cnt = 4'd5;
    bus.burst_dir = 1'b1; bus.SL = 1'b1;
    push(8'h81, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL abort_start: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b0;
    push(8'hC0, 1'b1, 1'b0);
    push(8'hE0, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL abort_shift: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    cr = 1'b1;
    push(8'h00, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL abort_reset: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    cr = 1'b0;
    push(8'h00, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL abort_no_done: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b1; bus.burst_cnt = 4'd2; bus.burst_dir = 1'b0; bus.SR = 1'b1;
    push(8'h00, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL resume_start: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.burst_start = 1'b0;
    push(8'h01, 1'b1, 1'b0);
    push(8'h03, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL resume_shift: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] m;
    logic       rot_on;
`ifdef ROTATE_EN
    rot_on = 1'b1;
`else
    rot_on = 1'b0;
`endif
    bus.mode = 2'b11; bus.par_in = 8'h81;
    push(8'h81, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL rot_load: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    bus.mode = 2'b00; bus.burst_start = 1'b1; bus.burst_cnt = 4'd4;
    bus.burst_dir = 1'b1; bus.rot = 1'b1; bus.SL = 1'b0;
    push(8'h81, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL rot_start: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    // rot drops after start; the latched value must still govern the burst
    bus.burst_start = 1'b0; bus.rot = 1'b0;
    m = 8'h81;
    for (int i = 0; i < 4; i++) begin
      m = {(rot_on ? m[0] : 1'b0), m[7:1]};
      push(m, (i < 3), (i == 3));
    end
    while (sb.size() > 0) begin
      step(); e = sb.pop_front(); checks++;
      if (bus.Q !== e.q || bus.busy !== e.busy || bus.done !== e.done) begin
        errors++;
        $display("FAIL rot_shift: Q=%h busy=%b done=%b, expected Q=%h busy=%b done=%b", bus.Q, bus.busy, bus.done, e.q, e.busy, e.done);
      end
    end
    checks++;
    if (bus.Q !== (rot_on ? 8'h18 : 8'h08)) begin
      errors++;
      $display("FAIL rot_final: Q=%h, expected %h", bus.Q, (rot_on ? 8'h18 : 8'h08));
    end
  endtask

  initial begin
    cr = 1'b1;
    bus.mode = 2'b00; bus.par_in = 8'h00; bus.SR = 1'b0; bus.SL = 1'b0;
    bus.burst_start = 1'b0; bus.burst_cnt = 4'd0; bus.burst_dir = 1'b0; bus.rot = 1'b0;
    step();
    cr = 1'b0;
    test_reset();
    test_modes();
    test_burst();
    test_zero_and_clamp();
    test_back_to_back();
    test_reset_mid_burst();
    test_rotate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
